// File: rtl/dec_ex_core_if.sv
// Decode-to-execute bus for dec_ex_core: operands and function code in,
// ALU result, flags, stage result and HI/LO accumulator out.
interface dec_ex_core_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Shamt;
  logic [5:0]  Func;
  logic        MULOp;
  logic        ACCEn;
  logic [31:0] ALUOut;
  logic        C;
  logic        Z;
  logic        O;
  logic        N;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, Shamt, Func, MULOp, ACCEn,
    input  ALUOut, C, Z, O, N, Out, HI, LO
  );

  modport slave (
    input  A, B, Shamt, Func, MULOp, ACCEn,
    output ALUOut, C, Z, O, N, Out, HI, LO
  );
endinterface

// File: rtl/dec_ex_core.sv
// Execute core: combinational 32-bit ALU with C/Z/O/N flags plus a registered 64-bit HI/LO
// accumulator. Define DEC_EX_MADD_MSUB_EN to build the multiply-add/subtract datapath.
module dec_ex_core (
  input  logic         Clock,
  input  logic         Reset,
  dec_ex_core_if.slave bus
);

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [5:0] M_MULT  = 6'h18;
  localparam logic [5:0] M_MULTU = 6'h19;
  localparam logic [5:0] M_MTHI  = 6'h11;
  localparam logic [5:0] M_MTLO  = 6'h13;
`ifdef DEC_EX_MADD_MSUB_EN
  localparam logic [5:0] M_MADD  = 6'h00;
  localparam logic [5:0] M_MADDU = 6'h01;
  localparam logic [5:0] M_MSUB  = 6'h04;
  localparam logic [5:0] M_MSUBU = 6'h05;
`endif

  logic [32:0] sum_s;
  logic [32:0] diff_s;
  logic        add_ovf_s;
  logic        sub_ovf_s;
  logic [31:0] alu_s;
  logic        c_s;
  logic        o_s;
  logic [31:0] out_s;
  logic [63:0] a_sx_s;
  logic [63:0] b_sx_s;
  logic [63:0] prod_signed_s;
  logic [63:0] prod_unsigned_s;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
`ifdef DEC_EX_MADD_MSUB_EN
  logic [63:0] acc_s;
`endif

  // Bit 32 of the difference is the unsigned borrow (A < B).
  assign sum_s     = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_s    = {1'b0, bus.A} - {1'b0, bus.B};
  assign add_ovf_s = (bus.A[31] == bus.B[31]) && (sum_s[31] != bus.A[31]);
  assign sub_ovf_s = (bus.A[31] != bus.B[31]) && (diff_s[31] != bus.A[31]);

  always_comb begin
    alu_s = 32'h0000_0000;
    c_s   = 1'b0;
    o_s   = 1'b0;
    if (!bus.MULOp) begin
      case (bus.Func)
        F_SLL:          alu_s = bus.B << bus.Shamt;
        F_SRL:          alu_s = bus.B >> bus.Shamt;
        F_SRA:          alu_s = $unsigned($signed(bus.B) >>> bus.Shamt);
        F_SLLV:         alu_s = bus.B << bus.A[4:0];
        F_SRLV:         alu_s = bus.B >> bus.A[4:0];
        F_SRAV:         alu_s = $unsigned($signed(bus.B) >>> bus.A[4:0]);
        F_ADD, F_ADDU: begin
          alu_s = sum_s[31:0];
          c_s   = sum_s[32];
          o_s   = add_ovf_s;
        end
        F_SUB, F_SUBU: begin
          alu_s = diff_s[31:0];
          c_s   = diff_s[32];
          o_s   = sub_ovf_s;
        end
        F_AND:          alu_s = bus.A & bus.B;
        F_OR:           alu_s = bus.A | bus.B;
        F_XOR:          alu_s = bus.A ^ bus.B;
        F_NOR:          alu_s = ~(bus.A | bus.B);
        F_SLT:          alu_s = {31'h0000_0000, ($signed(bus.A) < $signed(bus.B))};
        F_SLTU:         alu_s = {31'h0000_0000, (bus.A < bus.B)};
        default:        alu_s = 32'h0000_0000;
      endcase
    end else begin
      alu_s = 32'h0000_0000;
    end
  end

  // Low 64 bits of a 64x64 product of extended operands equal the exact 32x32 product.
  assign a_sx_s          = {{32{bus.A[31]}}, bus.A};
  assign b_sx_s          = {{32{bus.B[31]}}, bus.B};
  assign prod_signed_s   = a_sx_s * b_sx_s;
  assign prod_unsigned_s = {32'h0000_0000, bus.A} * {32'h0000_0000, bus.B};
`ifdef DEC_EX_MADD_MSUB_EN
  assign acc_s           = {hi_q, lo_q};
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (bus.MULOp && bus.ACCEn) begin
      case (bus.Func)
        M_MULT:  {hi_d, lo_d} = prod_signed_s;
        M_MULTU: {hi_d, lo_d} = prod_unsigned_s;
`ifdef DEC_EX_MADD_MSUB_EN
        M_MADD:  {hi_d, lo_d} = acc_s + prod_signed_s;
        M_MADDU: {hi_d, lo_d} = acc_s + prod_unsigned_s;
        M_MSUB:  {hi_d, lo_d} = acc_s - prod_signed_s;
        M_MSUBU: {hi_d, lo_d} = acc_s - prod_unsigned_s;
`endif
        M_MTHI:  hi_d = bus.A;
        M_MTLO:  lo_d = bus.A;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hi_q <= 32'h0000_0000;
      lo_q <= 32'h0000_0000;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Move-from reads the current registers: no bypass of an update landing this edge.
  always_comb begin
    out_s = alu_s;
    if (!bus.MULOp && (bus.Func == F_MFHI)) begin
      out_s = hi_q;
    end else if (!bus.MULOp && (bus.Func == F_MFLO)) begin
      out_s = lo_q;
    end else begin
      out_s = alu_s;
    end
  end

  assign bus.ALUOut = alu_s;
  assign bus.C      = c_s;
  assign bus.O      = o_s;
  assign bus.Z      = (alu_s == 32'h0000_0000);
  assign bus.N      = alu_s[31];
  assign bus.Out    = out_s;
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;

endmodule

// File: tb/tb_dec_ex_core.sv
// Randomized bench for dec_ex_core against an arithmetic reference model, plus directed literal cases.
module tb_dec_ex_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   check_en = 1'b0;
  logic [63:0] m_acc;
  logic [31:0] e_r;
  logic        e_c;
  logic        e_o;
  logic [31:0] e_out;

  dec_ex_core_if bus();
  dec_ex_core dut (.Clock(clk), .Reset(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                    input logic [5:0] f, input logic mul,
                                    output logic [31:0] r, output logic c, output logic o);
    longint          sa, sb, w;
    longint unsigned ua, ub, uw;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    r = 32'h0;
    c = 1'b0;
    o = 1'b0;
    if (!mul) begin
      case (f)
        6'h00: r = b << sh;
        6'h02: r = b >> sh;
        6'h03: begin w = sb >>> sh; r = w[31:0]; end
        6'h04: r = b << a[4:0];
        6'h06: r = b >> a[4:0];
        6'h07: begin w = sb >>> a[4:0]; r = w[31:0]; end
        6'h20, 6'h21: begin
          uw = ua + ub; r = uw[31:0]; c = uw[32];
          w = sa + sb; o = (w > 64'sd2147483647) || (w < -64'sd2147483648);
        end
        6'h22, 6'h23: begin
          r = a - b; c = (ua < ub);
          w = sa - sb; o = (w > 64'sd2147483647) || (w < -64'sd2147483648);
        end
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: r = (ua < ub) ? 32'd1 : 32'd0;
        default: r = 32'h0;
      endcase
    end
  endfunction

  function automatic logic [63:0] acc_next(input logic [63:0] acc, input logic [31:0] a,
                                           input logic [31:0] b, input logic [5:0] f);
    longint          sa, sb, sp;
    longint unsigned up;
    sa = $signed(a);
    sb = $signed(b);
    sp = sa * sb;
    up = a;
    up = up * b;
    acc_next = acc;
    case (f)
      6'h18: acc_next = sp;
      6'h19: acc_next = up;
`ifdef DEC_EX_MADD_MSUB_EN
      6'h00: acc_next = acc + sp;
      6'h01: acc_next = acc + up;
      6'h04: acc_next = acc - sp;
      6'h05: acc_next = acc - up;
`endif
      6'h11: acc_next = {a, acc[31:0]};
      6'h13: acc_next = {acc[63:32], a};
      default: acc_next = acc;
    endcase
  endfunction

  // Reference accumulator state
  always @(posedge clk or posedge rst) begin
    if (rst) m_acc <= 64'h0;
    else if (bus.MULOp === 1'b1 && bus.ACCEn === 1'b1) m_acc <= acc_next(m_acc, bus.A, bus.B, bus.Func);
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      model_alu(bus.A, bus.B, bus.Shamt, bus.Func, bus.MULOp, e_r, e_c, e_o);
      if (!bus.MULOp && bus.Func == 6'h10) e_out = m_acc[63:32];
      else if (!bus.MULOp && bus.Func == 6'h12) e_out = m_acc[31:0];
      else e_out = e_r;
      chk("aluout", bus.ALUOut, e_r);
      chk("c", bus.C, e_c);
      chk("o", bus.O, e_o);
      chk("z", bus.Z, (e_r == 32'h0));
      chk("n", bus.N, e_r[31]);
      chk("out", bus.Out, e_out);
      chk("hi", bus.HI, m_acc[63:32]);
      chk("lo", bus.LO, m_acc[31:0]);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [5:0] f, input logic mul, input logic en);
    bus.A = a; bus.B = b; bus.Shamt = sh; bus.Func = f; bus.MULOp = mul; bus.ACCEn = en;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0: rnd32 = 32'h0000_0000;
      1: rnd32 = 32'hFFFF_FFFF;
      2: rnd32 = 32'h7FFF_FFFF;
      3: rnd32 = 32'h8000_0000;
      4: rnd32 = $urandom_range(0, 40);
      default: rnd32 = $urandom;
    endcase
  endfunction

  logic [5:0] codes [0:23] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                               6'h10, 6'h12, 6'h18, 6'h19, 6'h01, 6'h05, 6'h11, 6'h13};

  initial begin
    drive(32'h0, 32'h0, 5'd0, 6'h10, 1'b0, 1'b0);
    rst = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_hi", bus.HI, 32'h0);
    chk("reset_lo", bus.LO, 32'h0);
    chk("reset_mfhi", bus.Out, 32'h0);
    cyc();
    rst = 1'b0;

    drive(32'h7FFF_FFFF, 32'h1, 5'd0, 6'h20, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_res", bus.ALUOut, 32'h8000_0000);
    chk("add_o", bus.O, 1'b1);
    chk("add_n", bus.N, 1'b1);
    chk("add_c", bus.C, 1'b0);
    chk("add_z", bus.Z, 1'b0);
    cyc();
    drive(32'h1, 32'h2, 5'd0, 6'h23, 1'b0, 1'b0);
    @(negedge clk);
    chk("subu_res", bus.ALUOut, 32'hFFFF_FFFF);
    chk("subu_c", bus.C, 1'b1);
    cyc();
    drive(32'h0, 32'h8000_0000, 5'd4, 6'h03, 1'b0, 1'b0);
    @(negedge clk);
    chk("sra", bus.ALUOut, 32'hF800_0000);
    cyc();
    drive(32'd33, 32'h1, 5'd0, 6'h04, 1'b0, 1'b0);
    @(negedge clk);
    chk("sllv", bus.ALUOut, 32'h2);
    cyc();
    drive(32'hFFFF_FFFF, 32'h0, 5'd0, 6'h2A, 1'b0, 1'b0);
    @(negedge clk);
    chk("slt", bus.ALUOut, 32'h1);
    cyc();
    drive(32'hFFFF_FFFF, 32'h0, 5'd0, 6'h2B, 1'b0, 1'b0);
    @(negedge clk);
    chk("sltu", bus.ALUOut, 32'h0);
    cyc();

    drive(32'hFFFF_FFFE, 32'h3, 5'd0, 6'h18, 1'b1, 1'b1);
    @(negedge clk);
    chk("mult_old_hi", bus.HI, 32'h0);
    chk("mult_out", bus.Out, 32'h0);
    cyc();
    drive(32'h0, 32'h0, 5'd0, 6'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
    chk("mfhi", bus.Out, 32'hFFFF_FFFF);
    cyc();
    drive(32'h5, 32'h7, 5'd0, 6'h18, 1'b1, 1'b0);
    @(negedge clk);
    chk("bubble_out", bus.Out, 32'h0);
    cyc();
    drive(32'h0, 32'h0, 5'd0, 6'h12, 1'b0, 1'b0);
    @(negedge clk);
    chk("bubble_lo", bus.Out, 32'hFFFF_FFFA);
    cyc();

    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 6'h19, 1'b1, 1'b1);
    cyc();
    drive(32'h1, 32'h1, 5'd0, 6'h01, 1'b1, 1'b1);
    @(negedge clk);
    chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
    chk("multu_lo", bus.LO, 32'h0000_0001);
    cyc();
    drive(32'h0, 32'h0, 5'd0, 6'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("maddu_hi", bus.HI, 32'hFFFF_FFFE);
`ifdef DEC_EX_MADD_MSUB_EN
    chk("maddu_lo", bus.LO, 32'h0000_0002);
`else
    chk("maddu_lo", bus.LO, 32'h0000_0001);
`endif
    cyc();

    drive(32'h1234, 32'h0, 5'd0, 6'h13, 1'b1, 1'b1);
    cyc();
    drive(32'h0, 32'h0, 5'd0, 6'h12, 1'b0, 1'b0);
    @(negedge clk);
    chk("mtlo", bus.Out, 32'h1234);
    cyc();
    drive(32'h5555, 32'h0, 5'd0, 6'h13, 1'b1, 1'b0);
    cyc();
    drive(32'h0, 32'h0, 5'd0, 6'h12, 1'b0, 1'b0);
    @(negedge clk);
    chk("mtlo_noen", bus.Out, 32'h1234);
    cyc();

    drive(32'h2, 32'h3, 5'd0, 6'h00, 1'b1, 1'b1);
    cyc();
    drive(32'h0, 32'h0, 5'd0, 6'h10, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_hi", bus.HI, 32'h0);
    chk("midrst_lo", bus.LO, 32'h0);
    chk("midrst_mfhi", bus.Out, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    drive(32'h2, 32'h3, 5'd0, 6'h00, 1'b1, 1'b1);
    cyc();
    drive(32'h0, 32'h0, 5'd0, 6'h12, 1'b0, 1'b0);
    @(negedge clk);
    chk("madd_after_rst_hi", bus.HI, 32'h0);
`ifdef DEC_EX_MADD_MSUB_EN
    chk("madd_after_rst_lo", bus.Out, 32'h6);
`else
    chk("madd_after_rst_lo", bus.Out, 32'h0);
`endif
    cyc();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(rnd32(), rnd32(), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : codes[$urandom_range(0, 23)],
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      cyc();
    end
    rst = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 6'h20, 1'b0, 1'b0);
    cyc();
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
